// File: rtl/register_file_arbiter_if.sv
// -----------------------------------------------------------------------------
// register_file_arbiter_if
// One requester channel of the register file arbiter: a valid/ready request
// (read of two addresses, or a write to address A) and a registered response.
//   valid, write, addr_a, addr_b, wdata : requester -> arbiter
//   ready                               : arbiter -> requester, grant this cycle
//   rsp_valid, rsp_data_a, rsp_data_b   : arbiter -> requester, one cycle later
// -----------------------------------------------------------------------------
interface register_file_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
);
    logic                  valid;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ready;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data_a;
    logic [DATA_WIDTH-1:0] rsp_data_b;

    modport master (
        output valid, write, addr_a, addr_b, wdata,
        input  ready, rsp_valid, rsp_data_a, rsp_data_b
    );

    modport slave (
        input  valid, write, addr_a, addr_b, wdata,
        output ready, rsp_valid, rsp_data_a, rsp_data_b
    );
endinterface

// File: rtl/register_file_arbiter.sv
// -----------------------------------------------------------------------------
// register_file_arbiter
// Access controller for a 2**ADDR_WIDTH x DATA_WIDTH register file with one
// write port and two asynchronous read ports. Zero-clears the whole file after
// reset or on clear_start_i, then shares the file between two requesters with
// round-robin arbitration. Every accepted request gets a registered response
// one cycle later (writes return the pre-write contents of address A).
//   clock_i, n_reset_i    : clock, asynchronous active-low reset
//   clear_start_i         : request a zero-clear sweep (sampled in SERVE only)
//   busy_o                : clear sweep in progress
//   req0_if, req1_if      : requester channels (slave side)
//   rf_write_enable_o, rf_address_a_o, rf_address_b_o, rf_write_data_o : to file
//   rf_read_data_a_i, rf_read_data_b_i : combinational read data from file
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_CLEAR | writing zero to address clear_count_q, no grants
// ST_SERVE | arbitrating requesters, or starting a new sweep on clear_start_i
// -----------------------------------------------------------------------------
module register_file_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                    clock_i,
    input  logic                    n_reset_i,
    input  logic                    clear_start_i,
    output logic                    busy_o,
    register_file_arbiter_if.slave  req0_if,
    register_file_arbiter_if.slave  req1_if,
    output logic                    rf_write_enable_o,
    output logic [ADDR_WIDTH-1:0]   rf_address_a_o,
    output logic [ADDR_WIDTH-1:0]   rf_address_b_o,
    output logic [DATA_WIDTH-1:0]   rf_write_data_o,
    input  logic [DATA_WIDTH-1:0]   rf_read_data_a_i,
    input  logic [DATA_WIDTH-1:0]   rf_read_data_b_i
);
    typedef enum logic {ST_CLEAR, ST_SERVE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clear_count_q, clear_count_d;
    logic                  ptr_q, ptr_d;
    logic                  grant0, grant1;

    logic                  rsp0_valid_q, rsp1_valid_q;
    logic [DATA_WIDTH-1:0] rsp0_data_a_q, rsp0_data_b_q;
    logic [DATA_WIDTH-1:0] rsp1_data_a_q, rsp1_data_b_q;

    always_comb begin
        state_d           = state_q;
        clear_count_d     = clear_count_q;
        ptr_d             = ptr_q;
        grant0            = 1'b0;
        grant1            = 1'b0;
        busy_o            = 1'b0;
        rf_write_enable_o = 1'b0;
        rf_address_a_o    = '0;
        rf_address_b_o    = '0;
        rf_write_data_o   = '0;
        case (state_q)
            ST_CLEAR: begin
                busy_o            = 1'b1;
                rf_write_enable_o = 1'b1;
                rf_address_a_o    = clear_count_q;
                // Count wraps to zero on the last address, so the next sweep
                // always starts from address 0 without an explicit reload.
                clear_count_d     = clear_count_q + 1'b1;
                if (clear_count_q == LAST_ADDR) begin
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (clear_start_i) begin
                    state_d = ST_CLEAR;
                end else if (req0_if.valid && (!req1_if.valid || !ptr_q)) begin
                    grant0 = 1'b1;
                end else if (req1_if.valid) begin
                    grant1 = 1'b1;
                end
                // Pointer names the requester that wins the next contention.
                if (grant0) begin
                    ptr_d             = 1'b1;
                    rf_write_enable_o = req0_if.write;
                    rf_address_a_o    = req0_if.addr_a;
                    rf_address_b_o    = req0_if.addr_b;
                    rf_write_data_o   = req0_if.wdata;
                end else if (grant1) begin
                    ptr_d             = 1'b0;
                    rf_write_enable_o = req1_if.write;
                    rf_address_a_o    = req1_if.addr_a;
                    rf_address_b_o    = req1_if.addr_b;
                    rf_write_data_o   = req1_if.wdata;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clock_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            state_q       <= ST_CLEAR;
            clear_count_q <= '0;
            ptr_q         <= 1'b0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp0_data_a_q <= '0;
            rsp0_data_b_q <= '0;
            rsp1_data_a_q <= '0;
            rsp1_data_b_q <= '0;
        end else begin
            state_q       <= state_d;
            clear_count_q <= clear_count_d;
            ptr_q         <= ptr_d;
            rsp0_valid_q  <= grant0;
            rsp1_valid_q  <= grant1;
            // Read data is sampled before the write lands: read-before-write.
            if (grant0) begin
                rsp0_data_a_q <= rf_read_data_a_i;
                rsp0_data_b_q <= rf_read_data_b_i;
            end
            if (grant1) begin
                rsp1_data_a_q <= rf_read_data_a_i;
                rsp1_data_b_q <= rf_read_data_b_i;
            end
        end
    end

    assign req0_if.ready      = grant0;
    assign req1_if.ready      = grant1;
    assign req0_if.rsp_valid  = rsp0_valid_q;
    assign req1_if.rsp_valid  = rsp1_valid_q;
    assign req0_if.rsp_data_a = rsp0_data_a_q;
    assign req0_if.rsp_data_b = rsp0_data_b_q;
    assign req1_if.rsp_data_a = rsp1_data_a_q;
    assign req1_if.rsp_data_b = rsp1_data_b_q;

endmodule

// File: tb/tb_register_file_arbiter.sv
module tb_register_file_arbiter;
    localparam int DW    = 16;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam logic [91:0] RESET_EXP = {1'b1, 4'b0, 64'b0, 1'b1, 6'b0, 16'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          n_reset;
    logic          clear_start;
    logic          busy;
    logic          rf_we;
    logic [AW-1:0] rf_aa, rf_ab;
    logic [DW-1:0] rf_wd, rf_rda, rf_rdb;

    register_file_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rq0 ();
    register_file_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rq1 ();

    register_file_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock_i           (clk),
        .n_reset_i         (n_reset),
        .clear_start_i     (clear_start),
        .busy_o            (busy),
        .req0_if           (rq0),
        .req1_if           (rq1),
        .rf_write_enable_o (rf_we),
        .rf_address_a_o    (rf_aa),
        .rf_address_b_o    (rf_ab),
        .rf_write_data_o   (rf_wd),
        .rf_read_data_a_i  (rf_rda),
        .rf_read_data_b_i  (rf_rdb)
    );

    // Register file: synchronous write, asynchronous reads, no reset.
    logic [DW-1:0] rf_mem [DEPTH];
    always @(posedge clk) if (rf_we) rf_mem[rf_aa] <= rf_wd;
    assign rf_rda = rf_mem[rf_aa];
    assign rf_rdb = rf_mem[rf_ab];

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: file contents, round-robin pointer, held response data.
    logic [DW-1:0] ref_mem [DEPTH];
    int            ptr_m;
    logic [DW-1:0] exp_a [2];
    logic [DW-1:0] exp_b [2];

    // Requester stimulus
    logic          v  [2];
    logic          w  [2];
    logic [AW-1:0] aa [2];
    logic [AW-1:0] ab [2];
    logic [DW-1:0] wd [2];

    task automatic drive();
        rq0.valid = v[0]; rq0.write = w[0]; rq0.addr_a = aa[0]; rq0.addr_b = ab[0]; rq0.wdata = wd[0];
        rq1.valid = v[1]; rq1.write = w[1]; rq1.addr_a = aa[1]; rq1.addr_b = ab[1]; rq1.wdata = wd[1];
    endtask

    task automatic model_reset();
        ptr_m = 0;
        for (int n = 0; n < 2; n++) begin
            exp_a[n] = '0;
            exp_b[n] = '0;
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    task automatic new_req(input int n, input bit force_valid);
        v[n]  = force_valid ? 1'b1 : ($urandom_range(0, 9) < 6);
        w[n]  = 1'($urandom_range(0, 1));
        aa[n] = AW'($urandom_range(0, 7));
        ab[n] = AW'($urandom_range(0, 7));
        wd[n] = DW'($urandom);
    endtask

    function automatic logic [91:0] reset_view();
        return {busy, rq1.ready, rq0.ready, rq1.rsp_valid, rq0.rsp_valid,
                rq0.rsp_data_a, rq0.rsp_data_b, rq1.rsp_data_a, rq1.rsp_data_b,
                rf_we, rf_aa, rf_wd};
    endfunction

    // One SERVE cycle: apply requests, predict grant and response from the
    // model, and return expected/observed {ready[1:0], rsp_valid[1:0], data}.
    task automatic step(output logic [1:0] g, output logic [67:0] exp_o, output logic [67:0] obs_o);
        drive();
        #1;
        g = 2'b00;
        if (!clear_start) begin
            if (v[0] && (!v[1] || ptr_m == 0)) g[0] = 1'b1;
            else if (v[1])                     g[1] = 1'b1;
        end
        for (int n = 0; n < 2; n++) begin
            if (g[n]) begin
                exp_a[n] = ref_mem[aa[n]];
                exp_b[n] = ref_mem[ab[n]];
                if (w[n]) ref_mem[aa[n]] = wd[n];
                ptr_m = 1 - n;
            end
        end
        if (clear_start) for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        obs_o[67:66] = {rq1.ready, rq0.ready};
        @(posedge clk);
        #1;
        obs_o[65:0] = {rq1.rsp_valid, rq0.rsp_valid, rq0.rsp_data_a, rq0.rsp_data_b,
                       rq1.rsp_data_a, rq1.rsp_data_b};
        exp_o = {g, g, exp_a[0], exp_b[0], exp_a[1], exp_b[1]};
    endtask

    task automatic test_reset();
        logic [1:0]  g;
        logic [67:0] e, o;
        int          cyc;
        n_reset = 1'b0;
        clear_start = 1'b0;
        for (int n = 0; n < 2; n++) begin
            new_req(n, 1'b0);
            v[n] = 1'b0;
        end
        drive();
        @(posedge clk);
        #1;
        tests_run++;
        if (reset_view() !== RESET_EXP) begin
            tests_failed++;
            $display("FAIL reset_values: got %h expected %h", reset_view(), RESET_EXP);
        end
        n_reset = 1'b1;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            tests_run++;
            if ({rf_we, rf_aa, rf_wd, rq1.ready, rq0.ready} !== {1'b1, AW'(cyc), 16'h0000, 2'b00}) begin
                tests_failed++;
                $display("FAIL sweep_cycle_%0d: got we=%b addr=%0d data=%h ready=%b%b expected we=1 addr=%0d data=0000 ready=00",
                         cyc, rf_we, rf_aa, rf_wd, rq1.ready, rq0.ready, cyc);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        tests_run++;
        if (cyc != 64) begin
            tests_failed++;
            $display("FAIL sweep_length: got %0d cycles expected 64", cyc);
        end
        model_reset();
        v[0] = 1'b1; w[0] = 1'b0; aa[0] = 6'd0; ab[0] = 6'd31;
        step(g, e, o);
        tests_run++;
        if (o !== e || o[47:16] !== 32'h0) begin
            tests_failed++;
            $display("FAIL read_0_31_after_clear: got %h expected %h", o, e);
        end
        aa[0] = 6'd63; ab[0] = 6'd63;
        step(g, e, o);
        tests_run++;
        if (o !== e || o[47:16] !== 32'h0) begin
            tests_failed++;
            $display("FAIL read_63_after_clear: got %h expected %h", o, e);
        end
        v[0] = 1'b0;
    endtask

    task automatic test_write_read();
        logic [1:0]  g;
        logic [67:0] e, o;
        v[0] = 1'b1; w[0] = 1'b1; aa[0] = 6'd5; ab[0] = 6'd0; wd[0] = 16'hBEEF;
        step(g, e, o);
        tests_run++;
        if (o !== e || rq0.rsp_data_a !== 16'h0000) begin
            tests_failed++;
            $display("FAIL write_beef_rsp: got %h expected %h", o, e);
        end
        w[0] = 1'b0; aa[0] = 6'd5; ab[0] = 6'd5;
        step(g, e, o);
        tests_run++;
        if (o !== e || {rq0.rsp_data_a, rq0.rsp_data_b} !== {16'hBEEF, 16'hBEEF}) begin
            tests_failed++;
            $display("FAIL read_back_beef: got %h expected %h", o, e);
        end
        v[0] = 1'b0;
    endtask

    task automatic test_single_then_contention();
        logic [1:0]  g;
        logic [67:0] e, o;
        v[0] = 1'b0;
        new_req(1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(g, e, o);
            tests_run++;
            if (o !== e || o[67:66] !== 2'b10) begin
                tests_failed++;
                $display("FAIL single_req1_%0d: got %h expected %h", i, o, e);
            end
            new_req(1, 1'b1);
        end
        new_req(0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(g, e, o);
            tests_run++;
            if (o !== e || o[67:66] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                tests_failed++;
                $display("FAIL contention_%0d: got %h expected %h", i, o, e);
            end
            for (int n = 0; n < 2; n++) if (g[n]) new_req(n, 1'b1);
        end
        v[0] = 1'b0;
        v[1] = 1'b0;
    endtask

    task automatic test_clear_start();
        logic [1:0]  g;
        logic [67:0] e, o;
        int          cyc;
        v[0] = 1'b1; w[0] = 1'b1; aa[0] = 6'd9; ab[0] = 6'd9; wd[0] = 16'h1234;
        step(g, e, o);
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("FAIL pre_clear_write: got %h expected %h", o, e);
        end
        w[0] = 1'b0;
        clear_start = 1'b1;
        step(g, e, o);
        tests_run++;
        if (o !== e || o[67:64] !== 4'b0000) begin
            tests_failed++;
            $display("FAIL clear_start_no_grant: got %h expected %h", o, e);
        end
        clear_start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            tests_run++;
            if ({rq0.ready, rf_aa, rf_we} !== {1'b0, AW'(cyc), 1'b1}) begin
                tests_failed++;
                $display("FAIL clear_sweep_%0d: got ready=%b addr=%0d we=%b expected ready=0 addr=%0d we=1",
                         cyc, rq0.ready, rf_aa, rf_we, cyc);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        tests_run++;
        if (cyc != 64) begin
            tests_failed++;
            $display("FAIL clear_length: got %0d cycles expected 64", cyc);
        end
        step(g, e, o);
        tests_run++;
        if (o !== e || rq0.rsp_data_a !== 16'h0000 || o[67:66] !== 2'b01) begin
            tests_failed++;
            $display("FAIL post_clear_read: got %h expected %h", o, e);
        end
        v[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [1:0]  g;
        logic [67:0] e, o;
        int          cyc;
        v[0] = 1'b1; w[0] = 1'b0; aa[0] = 6'd3; ab[0] = 6'd4;
        step(g, e, o);
        tests_run++;
        if (o !== e || rq0.rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_rsp: got %h expected %h", o, e);
        end
        #2;
        n_reset = 1'b0;
        v[0] = 1'b0;
        drive();
        #1;
        tests_run++;
        if (reset_view() !== RESET_EXP) begin
            tests_failed++;
            $display("FAIL reset_mid_transaction: got %h expected %h", reset_view(), RESET_EXP);
        end
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        tests_run++;
        if ({busy, rf_aa} !== {1'b1, 6'd20}) begin
            tests_failed++;
            $display("FAIL sweep_at_20: got busy=%b addr=%0d expected busy=1 addr=20", busy, rf_aa);
        end
        #2;
        n_reset = 1'b0;
        #1;
        tests_run++;
        if (reset_view() !== RESET_EXP) begin
            tests_failed++;
            $display("FAIL reset_mid_sweep: got %h expected %h", reset_view(), RESET_EXP);
        end
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            tests_run++;
            if ({rf_we, rf_aa, rf_wd} !== {1'b1, AW'(cyc), 16'h0000}) begin
                tests_failed++;
                $display("FAIL restart_sweep_%0d: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=0000",
                         cyc, rf_we, rf_aa, rf_wd, cyc);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        tests_run++;
        if (cyc != 64) begin
            tests_failed++;
            $display("FAIL restart_sweep_length: got %0d cycles expected 64", cyc);
        end
        model_reset();
    endtask

    task automatic test_random();
        logic [1:0]  g;
        logic [67:0] e, o;
        g = 2'b11;
        for (int i = 0; i < 300; i++) begin
            for (int n = 0; n < 2; n++) if (g[n] || !v[n]) new_req(n, 1'b0);
            step(g, e, o);
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL random_%0d: got %h expected %h", i, o, e);
            end
        end
        v[0] = 1'b0;
        v[1] = 1'b0;
        drive();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_reset = 1'b0;
        clear_start = 1'b0;
        test_reset();
        test_write_read();
        test_single_then_contention();
        test_clear_start();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
